// File: rtl/alu_sequencer.sv
// Issue-side controller: one instruction per valid/ready handshake, drives the ALU, registers result/flags, resolves jumps, latches HLT.
// Latency: accept in N, ALU driven in N+1, write-back/branch/illegal strobes in N+2, next accept in N+3 (one instruction per 3 cycles).
// Backpressure: in_ready is high only in IDLE; it drops in EXEC and DONE, and stays low after HLT until reset.
module alu_sequencer #(
    parameter int BITS_DATA = 32,
    parameter int BITS_REG  = 4,
    parameter int BITS_ADDR = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_opcode,
    input  logic [BITS_DATA-1:0] in_a,
    input  logic [BITS_DATA-1:0] in_b,
    input  logic [BITS_REG-1:0]  in_dest,
    input  logic [BITS_ADDR-1:0] in_target,
    output logic [4:0]           alu_opcode,
    output logic [BITS_DATA-1:0] alu_a,
    output logic [BITS_DATA-1:0] alu_b,
    input  logic [BITS_DATA-1:0] alu_result,
    input  logic                 alu_c,
    input  logic                 alu_s,
    input  logic                 alu_o,
    input  logic                 alu_z,
    output logic                 wb_valid,
    output logic [BITS_REG-1:0]  wb_dest,
    output logic [BITS_DATA-1:0] wb_data,
    output logic                 br_valid,
    output logic                 br_taken,
    output logic [BITS_ADDR-1:0] br_target,
    output logic [3:0]           flags,
    output logic                 illegal,
    output logic                 halted
);

    // Opcode encodings shared with the ALU.
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_NOT = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_NEG = 5'd5;
    localparam logic [4:0] OP_ADD = 5'd6;
    localparam logic [4:0] OP_SUB = 5'd7;
    localparam logic [4:0] OP_MUL = 5'd8;
    localparam logic [4:0] OP_DIV = 5'd9;
    localparam logic [4:0] OP_MOD = 5'd10;
    localparam logic [4:0] OP_LD  = 5'd11;
    localparam logic [4:0] OP_STR = 5'd12;
    localparam logic [4:0] OP_JMP = 5'd13;
    localparam logic [4:0] OP_JC  = 5'd14;
    localparam logic [4:0] OP_JS  = 5'd15;
    localparam logic [4:0] OP_JO  = 5'd16;
    localparam logic [4:0] OP_JZ  = 5'd17;
    localparam logic [4:0] OP_HLT = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched instruction fields.
    logic [4:0]           r_opcode;
    logic [BITS_DATA-1:0] r_a;
    logic [BITS_DATA-1:0] r_b;
    logic [BITS_REG-1:0]  r_dest;
    logic [BITS_ADDR-1:0] r_target;

    // Registered outputs.
    logic                 r_wb_valid;
    logic [BITS_REG-1:0]  r_wb_dest;
    logic [BITS_DATA-1:0] r_wb_data;
    logic                 r_br_valid;
    logic                 r_br_taken;
    logic [BITS_ADDR-1:0] r_br_target;
    logic [3:0]           r_flags;
    logic                 r_illegal;

    // Decode of the latched opcode.
    logic w_is_alu;
    logic w_is_jump;
    logic w_is_nop;
    logic w_is_hlt;
    logic w_jump_cond;
    logic w_handshake;

    assign w_handshake = in_valid && (r_state == S_IDLE);

    // Classify the latched opcode and evaluate the jump condition against the flag register.
    always_comb begin
        w_is_alu    = 1'b0;
        w_is_jump   = 1'b0;
        w_is_nop    = 1'b0;
        w_is_hlt    = 1'b0;
        w_jump_cond = 1'b0;
        case (r_opcode)
            OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB: w_is_alu = 1'b1;
            OP_JMP: begin w_is_jump = 1'b1; w_jump_cond = 1'b1;       end
            OP_JC:  begin w_is_jump = 1'b1; w_jump_cond = r_flags[3]; end
            OP_JS:  begin w_is_jump = 1'b1; w_jump_cond = r_flags[2]; end
            OP_JO:  begin w_is_jump = 1'b1; w_jump_cond = r_flags[1]; end
            OP_JZ:  begin w_is_jump = 1'b1; w_jump_cond = r_flags[0]; end
            OP_NOP: w_is_nop = 1'b1;
            OP_HLT: w_is_hlt = 1'b1;
            // XOR, MUL, DIV, MOD, LD, STR and undefined codes fall through as illegal.
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; HALT is only left through reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_handshake) w_next_state = S_EXEC;
            S_EXEC: w_next_state = w_is_hlt ? S_HALT : S_DONE;
            S_DONE: w_next_state = S_IDLE;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture the instruction fields on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opcode <= OP_NOP;
            r_a      <= '0;
            r_b      <= '0;
            r_dest   <= '0;
            r_target <= '0;
        end else if (w_handshake) begin
            r_opcode <= in_opcode;
            r_a      <= in_a;
            r_b      <= in_b;
            r_dest   <= in_dest;
            r_target <= in_target;
        end
    end

    // Retire at the end of EXEC: write-back, flags, branch or illegal; strobes last one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid  <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_data   <= '0;
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_flags     <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_br_valid <= 1'b0;
            r_br_taken <= 1'b0;
            r_illegal  <= 1'b0;
            if (r_state == S_EXEC) begin
                if (w_is_alu) begin
                    // Only legal ALU ops sample the ALU, so undefined ALU outputs never reach state.
                    r_wb_valid <= 1'b1;
                    r_wb_dest  <= r_dest;
                    r_wb_data  <= alu_result;
                    r_flags    <= {alu_c, alu_s, alu_o, alu_z};
                end else if (w_is_jump) begin
                    r_br_valid  <= 1'b1;
                    r_br_taken  <= w_jump_cond;
                    r_br_target <= r_target;
                end else if (!w_is_nop && !w_is_hlt) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    // The ALU sees the instruction only during EXEC and is parked on NOP otherwise.
    always_comb begin
        alu_opcode = OP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        if (r_state == S_EXEC) begin
            alu_opcode = r_opcode;
            alu_a      = r_a;
            alu_b      = r_b;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign halted    = (r_state == S_HALT);
    assign wb_valid  = r_wb_valid;
    assign wb_dest   = r_wb_dest;
    assign wb_data   = r_wb_data;
    assign br_valid  = r_br_valid;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;
    assign flags     = r_flags;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to the issue ports.
// Latency: checks outputs at accept+1 (EXEC) and accept+2 (DONE), sampling 1ns after the rising edge.
// Backpressure: waits for in_ready with a bounded cycle budget before each handshake.
module tb_alu_sequencer;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_NOT = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_NEG = 5'd5;
    localparam logic [4:0] OP_ADD = 5'd6;
    localparam logic [4:0] OP_SUB = 5'd7;
    localparam logic [4:0] OP_JMP = 5'd13;
    localparam logic [4:0] OP_JC  = 5'd14;
    localparam logic [4:0] OP_JS  = 5'd15;
    localparam logic [4:0] OP_JZ  = 5'd17;
    localparam logic [4:0] OP_HLT = 5'd18;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_dest;
    logic [15:0] in_target;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_c;
    logic        alu_s;
    logic        alu_o;
    logic        alu_z;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic        br_valid;
    logic        br_taken;
    logic [15:0] br_target;
    logic [3:0]  flags;
    logic        illegal;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer #(.BITS_DATA(32), .BITS_REG(4), .BITS_ADDR(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_dest    (in_dest),
        .in_target  (in_target),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_s      (alu_s),
        .alu_o      (alu_o),
        .alu_z      (alu_z),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .flags      (flags),
        .illegal    (illegal),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: unsupported opcodes return a junk pattern with all flags set,
    // so any capture of them shows up in wb_data or flags.
    logic [32:0] alu_wide;
    always_comb begin
        alu_wide   = '0;
        alu_result = 32'hDEAD_BEEF;
        alu_c      = 1'b1;
        alu_s      = 1'b1;
        alu_o      = 1'b1;
        alu_z      = 1'b1;
        case (alu_opcode)
            OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB: begin
                alu_c = 1'b0;
                alu_o = 1'b0;
                case (alu_opcode)
                    OP_NOT: alu_result = ~alu_a;
                    OP_AND: alu_result = alu_a & alu_b;
                    OP_OR:  alu_result = alu_a | alu_b;
                    OP_NEG: alu_result = -alu_a;
                    OP_ADD: begin
                        alu_wide   = {1'b0, alu_a} + {1'b0, alu_b};
                        alu_result = alu_wide[31:0];
                        alu_c      = alu_wide[32];
                        alu_o      = (alu_a[31] == alu_b[31]) && (alu_wide[31] != alu_a[31]);
                    end
                    default: begin
                        alu_wide   = {1'b0, alu_a} - {1'b0, alu_b};
                        alu_result = alu_wide[31:0];
                        alu_c      = alu_wide[32];
                        alu_o      = (alu_a[31] != alu_b[31]) && (alu_wide[31] != alu_a[31]);
                    end
                endcase
                alu_s = alu_result[31];
                alu_z = (alu_result == 32'd0);
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one instruction; returns 1ns into EXEC after checking the ALU drive.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] dest, input logic [15:0] tgt);
        int waited;
        waited = 0;
        while (!in_ready && waited < 10) begin
            tick();
            waited++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_dest   = dest;
        in_target = tgt;
        tick();
        in_valid  = 1'b0;
        check("exec_ready", 32'(in_ready), 32'd0);
        check("exec_aluop", 32'(alu_opcode), 32'(op));
    endtask

    int wb_seen;
    int stuck;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        in_dest   = '0;
        in_target = '0;
        tick();
        tick();
        // Reset state.
        check("rst_ready",  32'(in_ready),   32'd1);
        check("rst_aluop",  32'(alu_opcode), 32'(OP_NOP));
        check("rst_alua",   alu_a,           32'd0);
        check("rst_wbv",    32'(wb_valid),   32'd0);
        check("rst_wbdata", wb_data,         32'd0);
        check("rst_brv",    32'(br_valid),   32'd0);
        check("rst_flags",  32'(flags),      32'd0);
        check("rst_ill",    32'(illegal),    32'd0);
        check("rst_halt",   32'(halted),     32'd0);
        rst_n = 1'b1;
        tick();

        // Signed overflow on ADD.
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 4'd3, 16'h0);
        check("add1_exec_a", alu_a, 32'h7FFF_FFFF);
        check("add1_wbv_early", 32'(wb_valid), 32'd0);
        tick();
        check("add1_wbv",   32'(wb_valid), 32'd1);
        check("add1_dest",  32'(wb_dest),  32'd3);
        check("add1_data",  wb_data,       32'h8000_0000);
        check("add1_flags", 32'(flags),    32'b0110);
        check("add1_brv",   32'(br_valid), 32'd0);
        check("add1_ready", 32'(in_ready), 32'd0);
        tick();
        check("add1_wbv_off", 32'(wb_valid), 32'd0);
        check("add1_hold",    wb_data,       32'h8000_0000);
        check("add1_ready2",  32'(in_ready), 32'd1);
        check("idle_aluop",   32'(alu_opcode), 32'(OP_NOP));

        // SUB to zero, then JZ sees the fresh Z flag.
        issue(OP_SUB, 32'd5, 32'd5, 4'd2, 16'h0);
        tick();
        check("sub_data",  wb_data,      32'd0);
        check("sub_dest",  32'(wb_dest), 32'd2);
        check("sub_flags", 32'(flags),   32'b0001);
        tick();
        issue(OP_JZ, 32'd0, 32'd0, 4'd9, 16'h0040);
        tick();
        check("jz_brv",    32'(br_valid),  32'd1);
        check("jz_taken",  32'(br_taken),  32'd1);
        check("jz_tgt",    32'(br_target), 32'h0040);
        check("jz_wbv",    32'(wb_valid),  32'd0);
        check("jz_flags",  32'(flags),     32'b0001);
        tick();
        check("jz_brv_off", 32'(br_valid),  32'd0);
        check("jz_tgt_hold", 32'(br_target), 32'h0040);

        // Carry-out to zero; JS not taken, JC and JMP taken.
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd5, 16'h0);
        tick();
        check("add2_data",  wb_data,    32'd0);
        check("add2_flags", 32'(flags), 32'b1001);
        tick();
        issue(OP_JS, 32'd0, 32'd0, 4'd0, 16'h0080);
        tick();
        check("js_brv",   32'(br_valid),  32'd1);
        check("js_taken", 32'(br_taken),  32'd0);
        check("js_tgt",   32'(br_target), 32'h0080);
        tick();
        issue(OP_JC, 32'd0, 32'd0, 4'd0, 16'h0090);
        tick();
        check("jc_taken", 32'(br_taken), 32'd1);
        tick();
        issue(OP_JMP, 32'd0, 32'd0, 4'd0, 16'h1234);
        tick();
        check("jmp_taken", 32'(br_taken),  32'd1);
        check("jmp_tgt",   32'(br_target), 32'h1234);
        tick();

        // AND result through write-back.
        issue(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd1, 16'h0);
        tick();
        check("and_data",  wb_data,    32'h00F0_000F);
        check("and_flags", 32'(flags), 32'b0000);
        tick();

        // Unimplemented XOR: illegal strobe only.
        issue(OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 4'd6, 16'h0);
        tick();
        check("xor_ill",   32'(illegal),  32'd1);
        check("xor_wbv",   32'(wb_valid), 32'd0);
        check("xor_brv",   32'(br_valid), 32'd0);
        check("xor_flags", 32'(flags),    32'b0000);
        check("xor_data",  wb_data,       32'h00F0_000F);
        check("xor_dest",  32'(wb_dest),  32'd1);
        tick();
        check("xor_ill_off", 32'(illegal), 32'd0);

        // NOP completes through DONE silently.
        issue(OP_NOP, 32'd7, 32'd7, 4'd4, 16'h0);
        tick();
        check("nop_wbv",   32'(wb_valid), 32'd0);
        check("nop_ill",   32'(illegal),  32'd0);
        check("nop_brv",   32'(br_valid), 32'd0);
        check("nop_ready", 32'(in_ready), 32'd0);
        tick();
        check("nop_ready2", 32'(in_ready), 32'd1);

        // Reset during EXEC of an ADD cancels it.
        issue(OP_ADD, 32'h4000_0000, 32'h4000_0000, 4'd7, 16'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_wbv",   32'(wb_valid), 32'd0);
        check("mid_flags", 32'(flags),    32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        check("mid_dest",  32'(wb_dest),  32'd0);
        wb_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid) wb_seen++;
            tick();
        end
        check("mid_no_wb", 32'(wb_seen), 32'd0);

        // HLT with in_valid left asserted: stays halted until reset.
        issue(OP_HLT, 32'd0, 32'd0, 4'd0, 16'h0);
        in_valid  = 1'b1;
        in_opcode = OP_ADD;
        check("hlt_pre", 32'(halted), 32'd0);
        tick();
        check("hlt_halted", 32'(halted),   32'd1);
        check("hlt_ready",  32'(in_ready), 32'd0);
        check("hlt_wbv",    32'(wb_valid), 32'd0);
        check("hlt_ill",    32'(illegal),  32'd0);
        stuck = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (halted && !in_ready && !wb_valid) stuck++;
        end
        check("hlt_sticky", 32'(stuck), 32'd6);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check("hlt_rst_halt",  32'(halted),   32'd0);
        check("hlt_rst_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
